// File: rtl/prach_pkg.sv
// Shared types and widths for the PRACH mixer path.
// Consumed by prach_cmult and prach_mixer.
package prach_pkg;

    localparam int NUM_CHN  = 8;
    localparam int IQ_W     = 16;
    localparam int NCO_W    = 16;
    localparam int NCO_FRAC = 14;

    typedef logic [2:0] chn_t;

    typedef struct packed {
        logic signed [IQ_W-1:0] i;
        logic signed [IQ_W-1:0] q;
    } iq_t;

endpackage

// File: rtl/prach_cmult.sv
// Conjugate complex multiply (a * conj(c + js)) with round-half-up and saturation.
// Three register stages: products, sums, rounded/clamped result plus sat flag.
module prach_cmult
    import prach_pkg::*;
#(
    parameter int DW    = IQ_W,
    parameter int CW    = NCO_W,
    parameter int CFRAC = NCO_FRAC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] a_q,
    input  logic signed [CW-1:0] c,
    input  logic signed [CW-1:0] s,
    output logic signed [DW-1:0] y_i,
    output logic signed [DW-1:0] y_q,
    output logic                 sat
);

    localparam int PW = DW + CW;
    localparam int SW = PW + 1;

    localparam logic signed [SW-1:0] HALF = SW'(1) <<< (CFRAC - 1);
    localparam logic signed [SW-1:0] MAXV = SW'((2 ** (DW - 1)) - 1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    logic signed [PW-1:0] p_ic, p_qs, p_qc, p_is;
    logic signed [SW-1:0] s_i, s_q;
    logic signed [SW-1:0] r_i, r_q;
    logic signed [DW-1:0] c_i, c_q;
    logic                 clip_i, clip_q;

    always_comb begin
        r_i = (s_i + HALF) >>> CFRAC;
        r_q = (s_q + HALF) >>> CFRAC;
        c_i    = r_i[DW-1:0];
        c_q    = r_q[DW-1:0];
        clip_i = 1'b0;
        clip_q = 1'b0;
        if (r_i > MAXV) begin
            c_i    = MAXV[DW-1:0];
            clip_i = 1'b1;
        end else if (r_i < MINV) begin
            c_i    = MINV[DW-1:0];
            clip_i = 1'b1;
        end
        if (r_q > MAXV) begin
            c_q    = MAXV[DW-1:0];
            clip_q = 1'b1;
        end else if (r_q < MINV) begin
            c_q    = MINV[DW-1:0];
            clip_q = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_ic <= '0;
            p_qs <= '0;
            p_qc <= '0;
            p_is <= '0;
            s_i  <= '0;
            s_q  <= '0;
            y_i  <= '0;
            y_q  <= '0;
            sat  <= 1'b0;
        end else begin
            p_ic <= a_i * c;
            p_qs <= a_q * s;
            p_qc <= a_q * c;
            p_is <= a_i * s;
            s_i  <= SW'(p_ic) + SW'(p_qs);
            s_q  <= SW'(p_qc) - SW'(p_is);
            y_i  <= c_i;
            y_q  <= c_q;
            sat  <= clip_i | clip_q;
        end
    end

endmodule

// File: rtl/prach_mixer.sv
// TDM PRACH down-mixer: input register, conjugate multiply, tag/sync delay and status.
// Define PRACH_MIXER_SAT_CNT_EN to build the saturated-sample counter.
module prach_mixer
    import prach_pkg::*;
#(
    parameter int DW    = IQ_W,
    parameter int CW    = NCO_W,
    parameter int CFRAC = NCO_FRAC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] din_i,
    input  logic signed [DW-1:0] din_q,
    input  chn_t                 din_chn,
    input  logic signed [CW-1:0] nco_cos,
    input  logic signed [CW-1:0] nco_sin,
    input  chn_t                 nco_chn,
    input  logic                 sync_in,
    output logic signed [DW-1:0] dout_i,
    output logic signed [DW-1:0] dout_q,
    output chn_t                 dout_chn,
    output logic                 sync_out,
    input  logic                 ctrl_stat_clr,
    output logic [NUM_CHN-1:0]   stat_sat,
    output logic                 stat_misalign,
    output logic [15:0]          stat_sat_cnt
);

    logic signed [DW-1:0] s1_i, s1_q;
    logic signed [CW-1:0] s1_c, s1_s;
    chn_t                 chn_d [4];
    logic [3:0]           sync_d;
    logic                 misalign;
    logic                 sat;
    logic [NUM_CHN-1:0]   sat_set;

    assign misalign = (din_chn != nco_chn);
    assign sat_set  = sat ? (NUM_CHN'(1) << dout_chn) : '0;
    assign dout_chn = chn_d[3];
    assign sync_out = sync_d[3];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_i   <= '0;
            s1_q   <= '0;
            s1_c   <= '0;
            s1_s   <= '0;
            chn_d  <= '{default: '0};
            sync_d <= '0;
        end else begin
            s1_i     <= din_i;
            s1_q     <= din_q;
            s1_c     <= nco_cos;
            s1_s     <= nco_sin;
            chn_d[0] <= din_chn;
            for (int k = 1; k < 4; k++) begin
                chn_d[k] <= chn_d[k-1];
            end
            sync_d <= {sync_d[2:0], sync_in};
        end
    end

    prach_cmult #(
        .DW    (DW),
        .CW    (CW),
        .CFRAC (CFRAC)
    ) u_cmult (
        .clk   (clk),
        .rst_n (rst_n),
        .a_i   (s1_i),
        .a_q   (s1_q),
        .c     (s1_c),
        .s     (s1_s),
        .y_i   (dout_i),
        .y_q   (dout_q),
        .sat   (sat)
    );

    // A clear that coincides with an event leaves only that event recorded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_sat      <= '0;
            stat_misalign <= 1'b0;
        end else if (ctrl_stat_clr) begin
            stat_sat      <= sat_set;
            stat_misalign <= misalign;
        end else begin
            stat_sat      <= stat_sat | sat_set;
            stat_misalign <= stat_misalign | misalign;
        end
    end

`ifdef PRACH_MIXER_SAT_CNT_EN
    logic [15:0] sat_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (ctrl_stat_clr) begin
            sat_cnt <= {15'd0, sat};
        end else if (sat && sat_cnt != 16'hFFFF) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

    assign stat_sat_cnt = sat_cnt;
`else
    assign stat_sat_cnt = '0;
`endif

endmodule

// File: tb/tb_prach_mixer.sv
// Directed bench for prach_mixer: vector table plus latency, status and reset sequences.
// Counter expectations follow PRACH_MIXER_SAT_CNT_EN.
module tb_prach_mixer;

`ifdef PRACH_MIXER_SAT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] din_i, din_q, nco_cos, nco_sin;
    logic [2:0]         din_chn, nco_chn;
    logic               sync_in, ctrl_stat_clr;
    logic signed [15:0] dout_i, dout_q;
    logic [2:0]         dout_chn;
    logic               sync_out, stat_misalign;
    logic [7:0]         stat_sat;
    logic [15:0]        stat_sat_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prach_mixer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .din_i         (din_i),
        .din_q         (din_q),
        .din_chn       (din_chn),
        .nco_cos       (nco_cos),
        .nco_sin       (nco_sin),
        .nco_chn       (nco_chn),
        .sync_in       (sync_in),
        .dout_i        (dout_i),
        .dout_q        (dout_q),
        .dout_chn      (dout_chn),
        .sync_out      (sync_out),
        .ctrl_stat_clr (ctrl_stat_clr),
        .stat_sat      (stat_sat),
        .stat_misalign (stat_misalign),
        .stat_sat_cnt  (stat_sat_cnt)
    );

    typedef struct {
        logic signed [15:0] di, dq, c, s;
        logic [2:0]         chn;
        logic signed [15:0] ei, eq;
    } vec_t;

    vec_t tv [9];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int ecnt(input int v);
        return CNT_EN ? v : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int di, input int dq, input int c, input int s,
                         input int dc, input int nc);
        din_i   = 16'(di);
        din_q   = 16'(dq);
        nco_cos = 16'(c);
        nco_sin = 16'(s);
        din_chn = 3'(dc);
        nco_chn = 3'(nc);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " dout_i"}, dout_i, 0);
        chk({nm, " dout_q"}, dout_q, 0);
        chk({nm, " dout_chn"}, dout_chn, 0);
        chk({nm, " sync_out"}, sync_out, 0);
        chk({nm, " stat_sat"}, stat_sat, 0);
        chk({nm, " stat_misalign"}, stat_misalign, 0);
        chk({nm, " stat_sat_cnt"}, stat_sat_cnt, 0);
    endtask

    initial begin
        tv[0] = '{1234, -5678, 16384, 0, 3'd0, 1234, -5678};
        tv[1] = '{1000, 2000, 0, 16384, 3'd1, 2000, -1000};
        tv[2] = '{8192, 0, 1, 0, 3'd2, 1, 0};
        tv[3] = '{8191, 0, 1, 0, 3'd3, 0, 0};
        tv[4] = '{-8192, 0, 1, 0, 3'd4, 0, 0};
        tv[5] = '{-8193, 0, 1, 0, 3'd5, -1, 0};
        tv[6] = '{1000, 2000, 0, -16384, 3'd6, -2000, 1000};
        tv[7] = '{-32768, 0, 16384, 0, 3'd7, -32768, 0};
        tv[8] = '{100, 200, 8192, 8192, 3'd0, 150, 50};

        rst_n         = 1'b0;
        ctrl_stat_clr = 1'b0;
        sync_in       = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) step();
        chk_all_zero("reset");

        // cycle 0 is the release; sync pulse driven in cycle 10
        rst_n = 1'b1;
        repeat (10) step();
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        for (int t = 11; t <= 15; t++) begin
            chk($sformatf("sync_out@%0d", t), sync_out, (t == 14) ? 1 : 0);
            step();
        end

        for (int n = 0; n < 9; n++) begin
            drive(tv[n].di, tv[n].dq, tv[n].c, tv[n].s, tv[n].chn, tv[n].chn);
            repeat (4) step();
            chk($sformatf("vec%0d dout_i", n), dout_i, tv[n].ei);
            chk($sformatf("vec%0d dout_q", n), dout_q, tv[n].eq);
            chk($sformatf("vec%0d dout_chn", n), dout_chn, tv[n].chn);
        end
        step();
        chk("vec stat_sat", stat_sat, 0);
        chk("vec stat_misalign", stat_misalign, 0);
        chk("vec stat_sat_cnt", stat_sat_cnt, 0);

        for (int k = 0; k < 16; k++) begin
            drive(1234, -5678, 16384, 0, k % 8, k % 8);
            step();
            if (k >= 3) begin
                chk($sformatf("stream%0d dout_chn", k), dout_chn, (k - 3) % 8);
                chk($sformatf("stream%0d dout_i", k), dout_i, 1234);
            end
        end
        chk("stream stat_sat", stat_sat, 0);

        // misalign, then misalign coinciding with clear
        drive(1234, -5678, 16384, 0, 3, 4);
        step();
        chk("misalign set", stat_misalign, 1);
        drive(1234, -5678, 16384, 0, 3, 3);
        repeat (3) step();
        chk("misalign dout_chn", dout_chn, 3);
        chk("misalign sticky", stat_misalign, 1);
        drive(1234, -5678, 16384, 0, 2, 7);
        ctrl_stat_clr = 1'b1;
        step();
        chk("misalign clr collide", stat_misalign, 1);
        drive(1234, -5678, 16384, 0, 2, 2);
        ctrl_stat_clr = 1'b0;
        step();
        chk("misalign hold", stat_misalign, 1);
        ctrl_stat_clr = 1'b1;
        step();
        ctrl_stat_clr = 1'b0;
        chk("misalign cleared", stat_misalign, 0);

        // saturating sample on channel 5
        drive(32767, 32767, 11585, 11585, 5, 5);
        step();
        drive(1234, -5678, 16384, 0, 0, 0);
        repeat (3) step();
        chk("sat dout_i", dout_i, 32767);
        chk("sat dout_q", dout_q, 0);
        chk("sat dout_chn", dout_chn, 5);
        step();
        chk("sat stat_sat", stat_sat, 8'h20);
        chk("sat stat_sat_cnt", stat_sat_cnt, ecnt(1));
        step();
        chk("sat stat_sat hold", stat_sat, 8'h20);
        chk("sat cnt hold", stat_sat_cnt, ecnt(1));

        // clear arriving with a saturated sample on channel 2
        drive(32767, 32767, 11585, 11585, 2, 2);
        step();
        drive(1234, -5678, 16384, 0, 0, 0);
        repeat (3) step();
        ctrl_stat_clr = 1'b1;
        step();
        ctrl_stat_clr = 1'b0;
        chk("clr collide stat_sat", stat_sat, 8'h04);
        chk("clr collide cnt", stat_sat_cnt, ecnt(1));

`ifdef PRACH_MIXER_SAT_CNT_EN
        drive(32767, 32767, 11585, 11585, 7, 7);
        repeat (70000) step();
        chk("cnt saturate", stat_sat_cnt, 16'hFFFF);
        step();
        chk("cnt hold max", stat_sat_cnt, 16'hFFFF);
        chk("cnt stat_sat", stat_sat, 8'h84);
`endif

        // reset mid-stream must flush everything
        drive(1234, -5678, 16384, 0, 6, 6);
        sync_in = 1'b1;
        repeat (5) step();
        chk("pre-reset dout_chn", dout_chn, 6);
        rst_n = 1'b0;
        step();
        chk_all_zero("in reset 1");
        step();
        chk_all_zero("in reset 2");
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("post rel%0d dout_i", r), dout_i, 0);
            chk($sformatf("post rel%0d dout_q", r), dout_q, 0);
            chk($sformatf("post rel%0d dout_chn", r), dout_chn, 0);
            chk($sformatf("post rel%0d sync_out", r), sync_out, 0);
            step();
        end
        chk("first out dout_i", dout_i, 1234);
        chk("first out dout_q", dout_q, -5678);
        chk("first out dout_chn", dout_chn, 6);
        chk("first out sync_out", sync_out, 1);
        sync_in = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prach_mixer.md
Name: prach_mixer

Overview:
- Complex down-mixer for the 8-channel TDM PRACH path.
- Sits directly downstream of the PRACH NCO. Multiplies each input IQ sample by the conjugate of that channel's NCO phasor (cos − j·sin).
- Delivers rounded, saturated 16-bit IQ with channel tag and frame sync to the decimation chain.
- Also keeps saturation and channel-alignment status for software.

Parameters:
- DW, 16, input/output IQ sample width (signed).
- CW, 16, NCO cos/sin width (signed).
- CFRAC, 14, fractional bits of cos/sin (fi(1,16,14)); product right-shift amount.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- din_i  input  DW  input sample, I (signed)
- din_q  input  DW  input sample, Q (signed)
- din_chn  input  3  channel tag of din, upstream-aligned to the NCO output
- nco_cos  input  CW  NCO cosine, same cycle as din
- nco_sin  input  CW  NCO sine, same cycle as din
- nco_chn  input  3  NCO channel tag
- sync_in  input  1  frame sync, aligned to the channel-0 sample
- dout_i  output  DW  mixed sample, I
- dout_q  output  DW  mixed sample, Q
- dout_chn  output  3  channel tag of dout
- sync_out  output  1  sync_in delayed to align with dout
- ctrl_stat_clr  input  1  single-cycle pulse; clears all status
- stat_sat  output  8  sticky per-channel saturation flags
- stat_misalign  output  1  sticky: din_chn != nco_chn seen
- stat_sat_cnt  output  16  saturating count of saturated samples

Behaviour:
- Reset is synchronous. It is decided: rst_n, synchronous, active-low; clock clk. While rst_n=0, every pipeline register and every output is 0: dout_i, dout_q, dout_chn, sync_out, all stat_*.
- Continuous stream: one sample per clk, with no valid and no backpressure.
- Pipeline, fixed latency of 4 clk from inputs to dout:
  - S1 registers din_i/din_q/nco_cos/nco_sin/din_chn/sync_in.
  - S2 forms 4 full-precision products, each DW+CW bits.
  - S3 computes I = i·cos + q·sin and Q = q·cos − i·sin, each DW+CW+1 bits.
  - S4 rounds and saturates.
- dout_chn and sync_out take exactly the same 4-cycle delay.
- Rounding: add 2^(CFRAC−1), then arithmetic shift right by CFRAC (round half up).
- Saturation: clamp to [−2^(DW−1), 2^(DW−1)−1].
- A sample is "saturated" when I or Q (or both) clamps. It counts once per sample.
- On a saturated sample in S4, set stat_sat[dout_chn] and increment stat_sat_cnt by 1. stat_sat_cnt holds at 0xFFFF.
- Alignment check in S1: if din_chn != nco_chn, set stat_misalign. Data is still processed, and dout_chn carries din_chn.
- ctrl_stat_clr clears all stat_* in the next cycle.
- ctrl_stat_clr in the same cycle as a saturation event: the counter becomes 1 and only that channel's flag is set. Same rule for a simultaneous misalign event: stat_misalign becomes 1.
- sync_in has no effect on datapath or status. It is only delayed.
- Reset asserted mid-stream flushes the pipeline. After release, the first valid dout appears 4 clk after the first input.

Optional Feature:
- Macro PRACH_MIXER_SAT_CNT_EN.
- Defined: stat_sat_cnt is implemented as specified above.
- Undefined: no counter logic is built. stat_sat_cnt is tied to 0. stat_sat and stat_misalign are unchanged.

Decomposition:
- prach_pkg holds:
  - NUM_CHN = 8
  - typedef chn_t (logic [2:0])
  - IQ_W = 16, NCO_W = 16, NCO_FRAC = 14
  - typedef iq_t (packed struct of signed i, q)
- One sub-module, prach_cmult: the S2–S4 conjugate complex multiply with round/saturate. Fixed latency 3; it outputs a sat flag.
- prach_mixer wraps prach_cmult with S1, the tag/sync delay lines and the status logic.

Test Plan:
- Identity: cos=16384, sin=0, din=(1234, −5678), chn cycling 0..7 → dout=(1234, −5678) 4 clk later. dout_chn matches the delayed din_chn; no stat set.
- Quarter rotation: cos=0, sin=16384, din=(1000, 2000) → dout=(2000, −1000).
- Rounding: cos=1, sin=0, din_i=8192 → dout_i=1. din_i=8191 → 0. din_i=−8192 → 0. din_i=−8193 → −1.
- Saturation: din=(32767, 32767), cos=sin=11585, chn=5 → dout_i=32767, dout_q=0. stat_sat=8'h20, stat_sat_cnt=1. Repeat 70000 samples → cnt holds 0xFFFF.
- Clear collision: ctrl_stat_clr in the same cycle as a saturated S4 sample → stat_sat_cnt=1 next cycle. Misalign: din_chn=3, nco_chn=4 for one cycle → stat_misalign=1 until cleared.
- Reset and sync:
  - sync_in pulse at cycle 10 → sync_out pulse at cycle 14.
  - Assert rst_n=0 for 2 clk mid-stream → all outputs 0 during reset and in the 4 clk after release; no stale samples emerge.
